// File: rtl/spy_pkg.sv
// spy_pkg: shared definitions for the path-spy driver.
//   - spy_state_e : FSM state encoding
//   - CNT_W_DEF   : default width of the error counters
//   - TRIAL_W     : width of the trial counter (NUM_TRIALS up to 1023)
//   - DLY_W       : width of the capture-delay field
package spy_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    S1     = 3'd3,
    S2     = 3'd4,
    EVAL   = 3'd5,
    REPORT = 3'd6
  } spy_state_e;

  localparam int CNT_W_DEF = 8;
  localparam int TRIAL_W   = 10;
  localparam int DLY_W     = 4;

endpackage

// File: rtl/spy_path_driver_if.sv
// spy_path_driver_if: run-control and path-under-test signals of the spy driver.
//   START       : single-cycle run request            (master -> slave)
//   CAPTURE_DLY : extra wait cycles before sampling    (master -> slave)
//   PATH_OUT    : return bit from the path under test  (master -> slave)
//   PATH_IN     : launch bit into the path under test  (slave -> master)
//   BUSY/DONE   : run in progress / run-end pulse      (slave -> master)
//   PASS        : last run had no errors               (slave -> master)
//   LATE_CNT    : trials answered one sample late      (slave -> master)
//   INV_CNT     : trials answered with wrong polarity  (slave -> master)
interface spy_path_driver_if
  import spy_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             START;
  logic [DLY_W-1:0] CAPTURE_DLY;
  logic             PATH_OUT;
  logic             PATH_IN;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [CNT_W-1:0] LATE_CNT;
  logic [CNT_W-1:0] INV_CNT;

  modport master (
    output START, CAPTURE_DLY, PATH_OUT,
    input  PATH_IN, BUSY, DONE, PASS, LATE_CNT, INV_CNT
  );

  modport slave (
    input  START, CAPTURE_DLY, PATH_OUT,
    output PATH_IN, BUSY, DONE, PASS, LATE_CNT, INV_CNT
  );

endinterface

// File: rtl/spy_sat_cnt.sv
// spy_sat_cnt: saturating up-counter with synchronous clear.
//   clk_i   : clock (rising edge)
//   rst_n_i : synchronous active-low reset
//   clr_i   : clear to zero (wins over increment)
//   inc_i   : increment by one, holding at all-ones
//   cnt_o   : registered count
module spy_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/spy_path_driver.sv
// spy_path_driver: launches NUM_TRIALS toggles into a path under test and
// classifies each response as OK, LATE (right value one sample late) or
// INVERTED (wrong value on both samples).
//   CLK   : clock (rising edge)
//   RST_N : synchronous active-low reset
//   bus   : spy_path_driver_if.slave (START, CAPTURE_DLY, PATH_OUT in;
//           PATH_IN, BUSY, DONE, PASS, LATE_CNT, INV_CNT out)
// A trial is LAUNCH, CAPTURE_DLY cycles of WAIT, S1, S2, EVAL: 4+delay cycles.
// PATH_OUT is sampled raw; the whole point is to observe the path as-is.
module spy_path_driver
  import spy_pkg::*;
#(
  parameter int NUM_TRIALS = 16,
  parameter bit EXP_INV    = 1'b0,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic               CLK,
  input logic               RST_N,
  spy_path_driver_if.slave  bus
);

  localparam logic [TRIAL_W-1:0] TRIAL_LAST = TRIAL_W'(NUM_TRIALS);
  localparam logic [TRIAL_W-1:0] TRIAL_ONE  = {{(TRIAL_W-1){1'b0}}, 1'b1};
  localparam logic [DLY_W-1:0]   DLY_ZERO   = {DLY_W{1'b0}};
  localparam logic [DLY_W-1:0]   DLY_ONE    = {{(DLY_W-1){1'b0}}, 1'b1};

  spy_state_e         state_q;
  logic [DLY_W-1:0]   dly_q;
  logic [DLY_W-1:0]   wait_q;
  logic [TRIAL_W-1:0] trial_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;

  // Launch and sample flops must stay distinct, unmerged and unretimed so the
  // measured path is exactly the external one.
  (* keep = "true" *) logic path_in_q;
  (* keep = "true" *) logic s1_q;
  (* keep = "true" *) logic s2_q;

  logic             exp_s;
  logic             late_s;
  logic             inv_s;
  logic             clr_s;
  logic [CNT_W-1:0] late_cnt_s;
  logic [CNT_W-1:0] inv_cnt_s;

  // trial classification and counter control
  always_comb begin
    exp_s  = path_in_q ^ EXP_INV;
    late_s = 1'b0;
    inv_s  = 1'b0;
    clr_s  = (state_q == IDLE) && bus.START;
    if (state_q == EVAL) begin
      late_s = (s1_q != exp_s) && (s2_q == exp_s);
      inv_s  = (s1_q != exp_s) && (s2_q != exp_s);
    end else begin
      late_s = 1'b0;
      inv_s  = 1'b0;
    end
  end

  // run sequencer with registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      dly_q     <= DLY_ZERO;
      wait_q    <= DLY_ZERO;
      trial_q   <= {TRIAL_W{1'b0}};
      path_in_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            trial_q <= {TRIAL_W{1'b0}};
            dly_q   <= bus.CAPTURE_DLY;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        LAUNCH: begin
          path_in_q <= ~path_in_q;
          wait_q    <= dly_q;
          state_q   <= (dly_q != DLY_ZERO) ? WAIT : S1;
        end
        WAIT: begin
          wait_q <= wait_q - DLY_ONE;
          if (wait_q == DLY_ONE) begin
            state_q <= S1;
          end else begin
            state_q <= WAIT;
          end
        end
        S1: begin
          s1_q    <= bus.PATH_OUT;
          state_q <= S2;
        end
        S2: begin
          s2_q    <= bus.PATH_OUT;
          state_q <= EVAL;
        end
        EVAL: begin
          trial_q <= trial_q + TRIAL_ONE;
          if ((trial_q + TRIAL_ONE) == TRIAL_LAST) begin
            state_q <= REPORT;
          end else begin
            state_q <= LAUNCH;
          end
        end
        REPORT: begin
          // counters already hold the final trial's result here
          done_q  <= 1'b1;
          pass_q  <= (late_cnt_s == {CNT_W{1'b0}}) && (inv_cnt_s == {CNT_W{1'b0}});
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  spy_sat_cnt #(.W(CNT_W)) u_late_cnt (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .clr_i   (clr_s),
    .inc_i   (late_s),
    .cnt_o   (late_cnt_s)
  );

  spy_sat_cnt #(.W(CNT_W)) u_inv_cnt (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .clr_i   (clr_s),
    .inc_i   (inv_s),
    .cnt_o   (inv_cnt_s)
  );

  assign bus.PATH_IN  = path_in_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = pass_q;
  assign bus.LATE_CNT = late_cnt_s;
  assign bus.INV_CNT  = inv_cnt_s;

endmodule

// File: tb/tb_spy_path_driver.sv
// tb_spy_path_driver: directed and randomized checks of spy_path_driver.
// Edge 0 is the rising edge that samples an accepted START; outputs are
// observed 1 time unit after each rising edge.
module tb_spy_path_driver;
  import spy_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spy_path_driver_if #(.CNT_W(8)) if16 ();
  spy_path_driver_if #(.CNT_W(8)) if300 ();

  // loopback selection for the 16-trial instance: 0 wire, 1 inverter, 2 flop, 3 random
  int   mode   = 0;
  logic flop16 = 1'b0;
  logic rnd16  = 1'b0;
  logic samp [0:4095];

  always @(posedge clk) flop16 <= if16.PATH_IN;

  assign if16.PATH_OUT  = (mode == 0) ? if16.PATH_IN :
                          (mode == 1) ? ~if16.PATH_IN :
                          (mode == 2) ? flop16 : rnd16;
  assign if300.PATH_OUT = ~if300.PATH_IN;

  spy_path_driver #(.NUM_TRIALS(16), .EXP_INV(1'b0), .CNT_W(8)) dut16 (
    .CLK(clk), .RST_N(rst_n), .bus(if16.slave));

  spy_path_driver #(.NUM_TRIALS(300), .EXP_INV(1'b0), .CNT_W(8)) dut300 (
    .CLK(clk), .RST_N(rst_n), .bus(if300.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // One 16-trial run. Returns DONE edge (-1 if never seen) and PATH_IN toggles.
  // With scramble set, CAPTURE_DLY is randomized and START pulsed while busy,
  // strictly before edge glitch_until.
  task automatic run16(input logic [3:0] dly, input bit scramble, input int glitch_until,
                       output int done_edge, output int toggles);
    logic prev;
    int   n;
    bit   seen;
    done_edge = -1;
    toggles   = 0;
    @(negedge clk);
    if16.CAPTURE_DLY = dly;
    if16.START       = 1'b1;
    prev    = if16.PATH_IN;
    rnd16   = 1'($urandom);
    samp[0] = rnd16;
    @(posedge clk);
    #1;
    if16.START = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      if (scramble) begin
        if16.CAPTURE_DLY = 4'($urandom);
        if16.START = ((n + 1) < glitch_until) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      rnd16 = 1'($urandom);
      samp[n + 1] = rnd16;
      @(posedge clk);
      n++;
      #1;
      if (if16.PATH_IN !== prev) toggles++;
      prev = if16.PATH_IN;
      if (if16.DONE === 1'b1) begin
        seen      = 1'b1;
        done_edge = n;
      end
    end
    if16.START       = 1'b0;
    if16.CAPTURE_DLY = dly;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({if16.BUSY, if16.DONE, if16.PASS, if16.PATH_IN} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_flags16: got %b want 0000", {if16.BUSY, if16.DONE, if16.PASS, if16.PATH_IN});
    end
    n_cmp++;
    if ({if16.LATE_CNT, if16.INV_CNT} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_cnt16: got %h want 0000", {if16.LATE_CNT, if16.INV_CNT});
    end
    n_cmp++;
    if ({if300.BUSY, if300.DONE, if300.PASS, if300.PATH_IN, if300.LATE_CNT, if300.INV_CNT} !== 20'h00000) begin
      n_bad++;
      $display("FAIL reset_300: got %h want 00000",
               {if300.BUSY, if300.DONE, if300.PASS, if300.PATH_IN, if300.LATE_CNT, if300.INV_CNT});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_loopback;
    int de, tg;
    mode = 0;
    run16(4'd0, 1'b0, 0, de, tg);
    n_cmp++;
    if (de !== 65) begin n_bad++; $display("FAIL comb_done_edge: got %0d want 65", de); end
    n_cmp++;
    if ({if16.PASS, if16.BUSY} !== 2'b10) begin
      n_bad++; $display("FAIL comb_pass_busy: got %b want 10", {if16.PASS, if16.BUSY});
    end
    n_cmp++;
    if ({if16.LATE_CNT, if16.INV_CNT} !== 16'h0000) begin
      n_bad++; $display("FAIL comb_cnts: got %h want 0000", {if16.LATE_CNT, if16.INV_CNT});
    end
    n_cmp++;
    if (tg !== 16 || if16.PATH_IN !== 1'b0) begin
      n_bad++; $display("FAIL comb_toggles: got %0d/%b want 16/0", tg, if16.PATH_IN);
    end
    // DONE is a single pulse and results hold in IDLE, whatever CAPTURE_DLY does
    @(negedge clk);
    if16.CAPTURE_DLY = 4'd9;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if ({if16.DONE, if16.BUSY, if16.PASS} !== 3'b001) begin
      n_bad++; $display("FAIL comb_hold: got %b want 001", {if16.DONE, if16.BUSY, if16.PASS});
    end
  endtask

  task automatic test_inverter;
    int de, tg;
    mode = 1;
    run16(4'd0, 1'b0, 0, de, tg);
    n_cmp++;
    if (de !== 65) begin n_bad++; $display("FAIL inv_done_edge: got %0d want 65", de); end
    n_cmp++;
    if (if16.INV_CNT !== 8'd16 || if16.LATE_CNT !== 8'd0 || if16.PASS !== 1'b0) begin
      n_bad++;
      $display("FAIL inv_result: got inv=%0d late=%0d pass=%b want 16/0/0",
               if16.INV_CNT, if16.LATE_CNT, if16.PASS);
    end
  endtask

  task automatic test_flop_delay;
    int de, tg;
    mode = 2;
    run16(4'd0, 1'b0, 0, de, tg);
    n_cmp++;
    if (if16.LATE_CNT !== 8'd16 || if16.INV_CNT !== 8'd0 || if16.PASS !== 1'b0) begin
      n_bad++;
      $display("FAIL flop_d0: got late=%0d inv=%0d pass=%b want 16/0/0",
               if16.LATE_CNT, if16.INV_CNT, if16.PASS);
    end
    run16(4'd1, 1'b0, 0, de, tg);
    n_cmp++;
    if (de !== 81) begin n_bad++; $display("FAIL flop_d1_done_edge: got %0d want 81", de); end
    n_cmp++;
    if (if16.LATE_CNT !== 8'd0 || if16.INV_CNT !== 8'd0 || if16.PASS !== 1'b1) begin
      n_bad++;
      $display("FAIL flop_d1: got late=%0d inv=%0d pass=%b want 0/0/1",
               if16.LATE_CNT, if16.INV_CNT, if16.PASS);
    end
  endtask

  task automatic test_saturation;
    int n;
    int de;
    de = -1;
    @(negedge clk);
    if300.CAPTURE_DLY = 4'd0;
    if300.START       = 1'b1;
    @(posedge clk);
    #1;
    if300.START = 1'b0;
    n = 0;
    while (de < 0 && n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (if300.DONE === 1'b1) de = n;
    end
    n_cmp++;
    if (de !== 1201) begin n_bad++; $display("FAIL sat_done_edge: got %0d want 1201", de); end
    n_cmp++;
    if (if300.INV_CNT !== 8'd255 || if300.LATE_CNT !== 8'd0 || if300.PASS !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_result: got inv=%0d late=%0d pass=%b want 255/0/0",
               if300.INV_CNT, if300.LATE_CNT, if300.PASS);
    end
  endtask

  task automatic test_reset_mid_run;
    int n;
    int de, tg;
    bit stray;
    // delay 3: 7-cycle trials; trial 5 launches at edge 29 and waits until edge 32
    mode = 1;
    @(negedge clk);
    if16.CAPTURE_DLY = 4'd3;
    if16.START       = 1'b1;
    @(posedge clk);
    #1;
    if16.START = 1'b0;
    for (n = 0; n < 30; n++) @(posedge clk);
    #1;
    n_cmp++;
    if (if16.INV_CNT !== 8'd4 || if16.BUSY !== 1'b1) begin
      n_bad++; $display("FAIL midrun_pre: got inv=%0d busy=%b want 4/1", if16.INV_CNT, if16.BUSY);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({if16.BUSY, if16.PATH_IN, if16.DONE, if16.LATE_CNT, if16.INV_CNT} !== 19'd0) begin
      n_bad++;
      $display("FAIL midrun_reset: got busy=%b pin=%b done=%b late=%0d inv=%0d want all 0",
               if16.BUSY, if16.PATH_IN, if16.DONE, if16.LATE_CNT, if16.INV_CNT);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (if16.DONE !== 1'b0 || if16.BUSY !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin n_bad++; $display("FAIL midrun_no_done: got activity=1 want 0"); end
    mode = 0;
    run16(4'd2, 1'b0, 0, de, tg);
    n_cmp++;
    if (de !== 97 || if16.PASS !== 1'b1 || tg !== 16) begin
      n_bad++; $display("FAIL midrun_rerun: got edge=%0d pass=%b tg=%0d want 97/1/16", de, if16.PASS, tg);
    end
  endtask

  task automatic test_back_to_back;
    int de, tg;
    mode = 0;
    run16(4'd2, 1'b1, 97, de, tg);
    n_cmp++;
    if (de !== 97 || tg !== 16) begin
      n_bad++; $display("FAIL b2b_ignored_start: got edge=%0d tg=%0d want 97/16", de, tg);
    end
    // immediate restart in the DONE cycle
    mode = 1;
    run16(4'd0, 1'b0, 0, de, tg);
    n_cmp++;
    if (de !== 65 || if16.INV_CNT !== 8'd16 || if16.PASS !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_restart: got edge=%0d inv=%0d pass=%b want 65/16/0", de, if16.INV_CNT, if16.PASS);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      int   dd, de, tg, base, e_late, e_inv, e_edge;
      logic exp_b, b1, b2;
      logic [3:0] d;
      d      = 4'($urandom);
      dd     = int'(d);
      e_edge = 16 * (4 + dd) + 1;
      mode   = 3;
      run16(d, 1'b1, e_edge, de, tg);
      e_late = 0;
      e_inv  = 0;
      for (int t = 0; t < 16; t++) begin
        base  = 1 + t * (4 + dd);
        exp_b = ((t + 1) % 2 == 1) ? 1'b1 : 1'b0;
        b1    = samp[base + 1 + dd];
        b2    = samp[base + 2 + dd];
        if (b1 != exp_b) begin
          if (b2 == exp_b) e_late++;
          else e_inv++;
        end
      end
      n_cmp++;
      if (de !== e_edge) begin
        n_bad++; $display("FAIL rand_done_edge[%0d]: got %0d want %0d", it, de, e_edge);
      end
      n_cmp++;
      if (int'(if16.LATE_CNT) !== e_late || int'(if16.INV_CNT) !== e_inv ||
          if16.PASS !== ((e_late == 0 && e_inv == 0) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL rand_counts[%0d]: got late=%0d inv=%0d pass=%b want %0d/%0d",
                 it, if16.LATE_CNT, if16.INV_CNT, if16.PASS, e_late, e_inv);
      end
    end
  endtask

  initial begin
    if16.START        = 1'b0;
    if16.CAPTURE_DLY  = 4'd0;
    if300.START       = 1'b0;
    if300.CAPTURE_DLY = 4'd0;
    test_reset();
    test_comb_loopback();
    test_inverter();
    test_flop_delay();
    test_saturation();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
